// File: rtl/light_switch_bank_pkg.sv
// light_switch_bank_pkg: mode encodings and sizing helper shared by the switch bank.
package light_switch_bank_pkg;
  localparam int MODE_W = 2;
  typedef enum logic [MODE_W-1:0] {
    MODE_DIRECT = 2'd0,
    MODE_TOGGLE = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_OFF    = 2'd3
  } mode_e;
  function automatic int cnt_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/light_switch_bank_debounce.sv
// switch_debounce: synchronises one raw switch, debounces it and flags rising edges of the stable level.
module switch_debounce
  import light_switch_bank_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_raw,
  output logic level,
  output logic rise
);
  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  logic s1, s2, db, db_prev;
  logic [CW-1:0] cnt;
  // any return of s2 to the accepted level restarts the stability count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      db <= 1'b0;
      db_prev <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= sw_raw;
      s2 <= s1;
      db_prev <= db;
      if (s2 == db) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        db <= s2;
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
  assign level = db;
  assign rise = db & ~db_prev;
endmodule

// File: rtl/light_switch_bank.sv
// light_switch_bank: N debounced switches each driving a registered LED in a shared mode
// (direct, toggle, blink, off), with one blink prescaler common to all channels.
module light_switch_bank
  import light_switch_bank_pkg::*;
#(
  parameter int N_CH = 8,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BLINK_DIV = 12500000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   sw,
  input  logic [MODE_W-1:0] mode,
  output logic [N_CH-1:0]   Led,
  output logic [N_CH-1:0]   sw_level
);
  localparam int BW = cnt_width(BLINK_DIV);
  logic [N_CH-1:0] rise, tog, tog_d, led_d;
  logic [BW-1:0] bcnt;
  logic phase;
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk(clk),
      .rst_n(rst_n),
      .sw_raw(sw[c]),
      .level(sw_level[c]),
      .rise(rise[c])
    );
  end
  // toggle state follows presses in every mode so it survives mode changes
  always_comb begin
    tog_d = tog ^ rise;
    led_d = mode_e'(mode) == MODE_DIRECT ? sw_level :
            mode_e'(mode) == MODE_TOGGLE ? tog_d :
            mode_e'(mode) == MODE_BLINK  ? sw_level & {N_CH{phase}} : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tog <= '0;
      Led <= '0;
      bcnt <= '0;
      phase <= 1'b0;
    end else begin
      tog <= tog_d;
      Led <= led_d;
      bcnt <= bcnt == BW'(BLINK_DIV - 1) ? '0 : bcnt + 1'b1;
      phase <= bcnt == BW'(BLINK_DIV - 1) ? ~phase : phase;
    end
  end
endmodule
